tt_prog_loader: RTL

- Serial program loader that sits directly upstream of the tiny RISC core's instruction memory.
- Receives a framed bit stream on three pins, assembles bytes, writes them sequentially into instruction memory through a single write port, and validates the frame with a checksum.
- Holds the core in reset/stall (cpu_hold) until a frame loads cleanly. Replaces ad-hoc parallel loading over uio_in.

---
 rtl/tt_prog_loader.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/tt_prog_loader.sv
// rtl/tt_prog_loader.sv - serial framed program loader for the core's instruction memory
//
// Purpose: receives a framed bit stream (header N, N data bytes, checksum),
// writes the data bytes sequentially into instruction memory and holds the
// core until a frame has loaded with a matching checksum.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   ser_cs_n          frame select (active low), asynchronous to clk
//   ser_clk           serial bit clock, data sampled on its rising edge
//   ser_data          serial data, MSB first
//   mem_we            one-cycle instruction memory write strobe
//   mem_addr          write address
//   mem_wdata         write data
//   cpu_hold          1 = core must not fetch
//   load_done         last frame loaded and checksum matched
//   load_err          last frame failed (bad length, bad checksum, aborted)
//   byte_count        data bytes written in the current/last frame
module tt_prog_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ser_cs_n,
    input  logic                  ser_clk,
    input  logic                  ser_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   byte_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;
    localparam logic [2:0]            BIT_LAST = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic                  cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d, cs_prev_q, cs_prev_d;
    logic                  sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_prev_q, sclk_prev_d;
    logic                  sdat_s1_q, sdat_s1_d, sdat_s2_q, sdat_s2_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH:0]   n_q, n_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [ADDR_WIDTH:0]   byte_count_q, byte_count_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;

    logic                  sclk_rise, cs_fall, cs_rise, byte_done, in_frame;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic [ADDR_WIDTH:0]   bc_inc;

    always_comb begin
        sclk_rise = sclk_s2_q & ~sclk_prev_q;
        cs_fall   = ~cs_s2_q & cs_prev_q;
        cs_rise   = cs_s2_q & ~cs_prev_q;
        // Gating with the synchronised select makes an abort win over a
        // byte completing in the same cycle.
        byte_done = ~cs_s2_q & sclk_rise & (bit_cnt_q == BIT_LAST);
        rx_byte   = {shift_q[DATA_WIDTH-2:0], sdat_s2_q};
        bc_inc    = byte_count_q + CNT_ONE;
        in_frame  = (state_q == S_HEADER) || (state_q == S_DATA) || (state_q == S_CHECK);

        cs_s1_d     = ser_cs_n;
        cs_s2_d     = cs_s1_q;
        cs_prev_d   = cs_s2_q;
        sclk_s1_d   = ser_clk;
        sclk_s2_d   = sclk_s1_q;
        sclk_prev_d = sclk_s2_q;
        sdat_s1_d   = ser_data;
        sdat_s2_d   = sdat_s1_q;

        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (cs_s2_q) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        state_d      = state_q;
        n_d          = n_q;
        index_d      = index_q;
        byte_count_d = byte_count_q;
        sum_d        = sum_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        if (cs_fall) begin
            state_d      = S_HEADER;
            index_d      = '0;
            byte_count_d = '0;
            sum_d        = '0;
        end else if (cs_rise && in_frame) begin
            state_d = S_ERROR;
        end else if (byte_done) begin
            case (state_q)
                S_HEADER: begin
                    if ((rx_byte != '0) && (int'(rx_byte) <= DEPTH)) begin
                        n_d     = rx_byte[ADDR_WIDTH:0];
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
                S_DATA: begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = index_q;
                    mem_wdata_d  = rx_byte;
                    byte_count_d = bc_inc;
                    sum_d        = sum_q + rx_byte;
                    // Index stops at N-1 so the address never wraps.
                    if (bc_inc == n_q) state_d = S_CHECK;
                    else               index_d = index_q + IDX_ONE;
                end
                S_CHECK: state_d = (rx_byte == sum_q) ? S_DONE : S_ERROR;
                default: ;
            endcase
        end

        cpu_hold_d  = (state_d != S_DONE);
        load_done_d = (state_d == S_DONE);
        load_err_d  = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            // Select synchronisers start at the idle (deselected) level so a
            // released reset with the line idle is not seen as a frame edge.
            cs_s1_q      <= 1'b1;
            cs_s2_q      <= 1'b1;
            cs_prev_q    <= 1'b1;
            sclk_s1_q    <= 1'b0;
            sclk_s2_q    <= 1'b0;
            sclk_prev_q  <= 1'b0;
            sdat_s1_q    <= 1'b0;
            sdat_s2_q    <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            n_q          <= '0;
            index_q      <= '0;
            byte_count_q <= '0;
            sum_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_s1_q      <= cs_s1_d;
            cs_s2_q      <= cs_s2_d;
            cs_prev_q    <= cs_prev_d;
            sclk_s1_q    <= sclk_s1_d;
            sclk_s2_q    <= sclk_s2_d;
            sclk_prev_q  <= sclk_prev_d;
            sdat_s1_q    <= sdat_s1_d;
            sdat_s2_q    <= sdat_s2_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            n_q          <= n_d;
            index_q      <= index_d;
            byte_count_q <= byte_count_d;
            sum_q        <= sum_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign byte_count = byte_count_q;

endmodule
